// File: rtl/mod_sqrt_unit.sv
// Restoring digit-by-digit integer square root: one root bit per clock, valid/ready on both sides.
// Produces mag = floor(sqrt(r)) and the exact remainder rem = r - mag*mag.
module mod_sqrt_unit #(
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH = IN_WIDTH / 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  r,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] mag,
    output logic [OUT_WIDTH:0]   rem
);

    localparam int unsigned CntW  = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
    localparam int unsigned RemW  = OUT_WIDTH + 2;
    localparam int unsigned TrialW = RemW + 2;
    localparam logic [CntW-1:0] LastCnt = CntW'(OUT_WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [IN_WIDTH-1:0]  rad_q, rad_d;
    logic [OUT_WIDTH-1:0] root_q, root_d;
    logic [RemW-1:0]      rem_q, rem_d;
    logic [CntW-1:0]      cnt_q, cnt_d;

    logic [TrialW-1:0] trial;
    logic [TrialW-1:0] divisor;
    logic              fits;
    logic              accept;
    logic              last_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept)    state_d = StCalc;
            StCalc: if (last_step) state_d = StDone;
            StDone: if (out_ready) state_d = StIdle;
            default:               state_d = StIdle;
        endcase
    end

    // Outputs read zero outside DONE so an aborted result is never visible.
    always_comb begin
        in_ready  = (state_q == StIdle) && !rst;
        out_valid = (state_q == StDone);
        mag       = out_valid ? root_q : '0;
        rem       = out_valid ? rem_q[OUT_WIDTH:0] : '0;
    end

    assign accept    = in_valid && in_ready;
    assign last_step = (state_q == StCalc) && (cnt_q == LastCnt);

    // Bring down the next two radicand bits and try subtracting 4*root+1.
    assign trial   = {rem_q, rad_q[IN_WIDTH-1 -: 2]};
    assign divisor = {2'b00, root_q, 2'b01};
    assign fits    = (trial >= divisor);

    always_comb begin
        rad_d  = rad_q;
        root_d = root_q;
        rem_d  = rem_q;
        cnt_d  = cnt_q;
        if (accept) begin
            rad_d  = r;
            root_d = '0;
            rem_d  = '0;
            cnt_d  = '0;
        end else if (state_q == StCalc) begin
            rad_d  = rad_q << 2;
            root_d = {root_q[OUT_WIDTH-2:0], fits};
            rem_d  = fits ? RemW'(trial - divisor) : RemW'(trial);
            cnt_d  = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rad_q  <= '0;
            root_q <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
        end else begin
            rad_q  <= rad_d;
            root_q <= root_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mod_sqrt_unit.sv
// Directed and randomized bench for mod_sqrt_unit: corners, latency, throughput,
// backpressure, mid-operation reset and ignored input during CALC.
module tb_mod_sqrt_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] r;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] mag;
    logic [16:0] rem;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mod_sqrt_unit #(
        .IN_WIDTH (32),
        .OUT_WIDTH(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .r        (r),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .mag      (mag),
        .rem      (rem)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one radicand through; lat counts edges from accept to the first out_valid cycle.
    task automatic do_txn(input logic [31:0] rv, input bit rnd_ready, output logic [15:0] m,
                          output logic [16:0] rm, output int lat, output bit to);
        int n;
        to  = 1'b0;
        m   = '0;
        rm  = '0;
        lat = 0;
        n   = 0;
        r         = rv;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            to       = 1'b1;
            in_valid = 1'b0;
            return;
        end
        tick();
        in_valid = 1'b0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        if (!out_valid) begin
            to = 1'b1;
            return;
        end
        m  = mag;
        rm = rem;
        for (int k = 0; k < 10; k++) begin
            out_ready = (rnd_ready && k < 8) ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            if (out_ready) break;
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        r         = '0;
        repeat (3) tick();
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || mag !== 16'h0 || rem !== 17'h0) begin
            bad++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b mag=%h rem=%h, want 0 0 0 0",
                     in_ready, out_valid, mag, rem);
        end
        rst = 1'b0;
        tick();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_corners();
        logic [31:0] cr [4];
        logic [15:0] em [4];
        logic [16:0] er [4];
        logic [15:0] m;
        logic [16:0] rm;
        int          lat;
        bit          to;
        cr[0] = 32'h0000_0000; em[0] = 16'h0000; er[0] = 17'h0_0000;
        cr[1] = 32'h0000_0001; em[1] = 16'h0001; er[1] = 17'h0_0000;
        cr[2] = 32'hFFFF_FFFF; em[2] = 16'hFFFF; er[2] = 17'h1_FFFE;
        cr[3] = 32'hFFFE_0001; em[3] = 16'hFFFF; er[3] = 17'h0_0000;
        for (int i = 0; i < 4; i++) begin
            do_txn(cr[i], 1'b0, m, rm, lat, to);
            total++;
            if (to || m !== em[i] || rm !== er[i]) begin
                bad++;
                $display("FAIL corner r=%h: mag=%h rem=%h timeout=%0b, want mag=%h rem=%h",
                         cr[i], m, rm, to, em[i], er[i]);
            end
        end
    endtask

    task automatic test_latency();
        logic [15:0] m;
        logic [16:0] rm;
        int          lat;
        bit          to;
        do_txn(32'd144, 1'b0, m, rm, lat, to);
        total++;
        if (to || lat != 16) begin
            bad++;
            $display("FAIL latency: edges=%0d timeout=%0b, want 16", lat, to);
        end
        total++;
        if (m !== 16'd12 || rm !== 17'd0) begin
            bad++;
            $display("FAIL sqrt144: mag=%0d rem=%0d, want 12 0", m, rm);
        end
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL after_consume: in_ready=%b out_valid=%b, want 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int          acc_edge [2];
        logic [15:0] res_m [2];
        logic [16:0] res_r [2];
        int          na   = 0;
        int          nres = 0;
        bit          pend;
        r         = 32'd1000;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 80 && nres < 2; cyc++) begin
            pend = in_ready && in_valid;
            if (out_valid && out_ready) begin
                res_m[nres] = mag;
                res_r[nres] = rem;
                nres++;
            end
            tick();
            if (pend) begin
                acc_edge[na] = cyc;
                na++;
                if (na == 1) r = 32'd1001;
                else         in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        total++;
        if (na != 2 || nres != 2) begin
            bad++;
            $display("FAIL b2b_count: accepts=%0d results=%0d, want 2 2", na, nres);
        end else begin
            total++;
            if (acc_edge[1] - acc_edge[0] != 18) begin
                bad++;
                $display("FAIL b2b_spacing: edges=%0d, want 18", acc_edge[1] - acc_edge[0]);
            end
            total++;
            if (res_m[0] !== 16'd31 || res_r[0] !== 17'd39) begin
                bad++;
                $display("FAIL b2b_first: mag=%0d rem=%0d, want 31 39", res_m[0], res_r[0]);
            end
            total++;
            if (res_m[1] !== 16'd31 || res_r[1] !== 17'd40) begin
                bad++;
                $display("FAIL b2b_second: mag=%0d rem=%0d, want 31 40", res_m[1], res_r[1]);
            end
        end
        tick();
    endtask

    task automatic test_backpressure();
        int n = 0;
        r         = 32'd50;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (!out_valid) begin
            bad++;
            $display("FAIL bp_wait: out_valid=%b after %0d cycles, want 1", out_valid, n);
        end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (mag !== 16'd7 || rem !== 17'd1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold cycle %0d: mag=%0d rem=%0d out_valid=%b in_ready=%b, want 7 1 1 0",
                         i, mag, rem, out_valid, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] m;
        logic [16:0] rm;
        int          lat;
        bit          to;
        bit          seen = 1'b0;
        int          n    = 0;
        r         = 32'd400;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b0 || mag !== 16'h0 || rem !== 17'h0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid: out_valid=%b mag=%h rem=%h in_ready=%b, want 0 0 0 0",
                     out_valid, mag, rem, in_ready);
        end
        // in_valid together with reset must not be accepted.
        in_valid = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL rst_discard: out_valid rose=%b, want 0", seen);
        end
        do_txn(32'd400, 1'b0, m, rm, lat, to);
        total++;
        if (to || m !== 16'd20 || rm !== 17'd0 || lat != 16) begin
            bad++;
            $display("FAIL rst_recover: mag=%0d rem=%0d lat=%0d timeout=%0b, want 20 0 16",
                     m, rm, lat, to);
        end
    endtask

    task automatic test_ignored_input();
        bit busy_ok = 1'b1;
        int n       = 0;
        r         = 32'd10000;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        tick();
        for (int i = 0; i < 16; i++) begin
            in_valid = ~in_valid;
            r        = $urandom;
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        total++;
        if (!busy_ok) begin
            bad++;
            $display("FAIL ign_ready: in_ready went high during CALC, want 0");
        end
        total++;
        if (out_valid !== 1'b1 || mag !== 16'd100 || rem !== 17'd0) begin
            bad++;
            $display("FAIL ign_result: out_valid=%b mag=%0d rem=%0d, want 1 100 0",
                     out_valid, mag, rem);
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL ign_consume: out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_random();
        logic [15:0]     m;
        logic [16:0]     rm;
        int              lat;
        bit              to;
        logic [31:0]     rv;
        longint unsigned rl, ml, sq, nx;
        for (int i = 0; i < 2000; i++) begin
            rv = $urandom;
            do_txn(rv, 1'b1, m, rm, lat, to);
            rl = 64'(rv);
            ml = 64'(m);
            sq = ml * ml;
            nx = (ml + 1) * (ml + 1);
            total++;
            if (to || sq > rl || rl >= nx) begin
                bad++;
                $display("FAIL rand_mag r=%h: mag=%h timeout=%0b, want mag^2<=r<(mag+1)^2",
                         rv, m, to);
            end
            total++;
            if (64'(rm) != rl - sq || 64'(rm) > 2 * ml) begin
                bad++;
                $display("FAIL rand_rem r=%h: rem=%h, want %h (<= 2*mag)", rv, rm, rl - sq);
            end
            total++;
            if (lat != 16) begin
                bad++;
                $display("FAIL rand_lat r=%h: edges=%0d, want 16", rv, lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_corners();
        test_latency();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_ignored_input();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
